// File: rtl/id_checker_pkg.sv
// id_checker_pkg: definitions shared by the login stages.
// Holds the search FSM state encoding, the ID digit count, the ID/password
// ROM read latency and the default internal slot reported for a guest.
package id_checker_pkg;

  localparam int unsigned ID_DIGITS  = 4;
  localparam int unsigned ROM_WAIT   = 2;
  localparam logic [2:0]  GUEST_SLOT = 3'd7;

  typedef enum logic [3:0] {
    S_DIG1,
    S_DIG2,
    S_DIG3,
    S_DIG4,
    S_CHECK,
    S_CYC1,
    S_CYC2,
    S_CATCH,
    S_EVAL,
    S_COMPARE,
    S_MATCH,
    S_LOCKED,
    S_FAIL
  } state_t;

endpackage

// File: rtl/id_checker_bcd_digit_shifter.sv
// bcd_digit_shifter: assembles a 4-digit BCD ID, most significant digit first.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   i_capture   - store i_digit at position i_pos this cycle
//   i_pos       - digit position 0..3 (0 = userID[15:12])
//   i_digit     - BCD digit
//   o_value     - assembled ID
//   o_bad       - sticky: some digit of the current ID was greater than 9
module bcd_digit_shifter
  import id_checker_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_capture,
  input  logic [1:0]  i_pos,
  input  logic [3:0]  i_digit,
  output logic [15:0] o_value,
  output logic        o_bad
);

  logic [15:0] r_value;
  logic        r_bad;
  logic        w_digit_bad;

  assign w_digit_bad = (i_digit > 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
      r_bad   <= 1'b0;
    end else if (i_capture) begin
      case (i_pos)
        2'd0:    r_value[15:12] <= i_digit;
        2'd1:    r_value[11:8]  <= i_digit;
        2'd2:    r_value[7:4]   <= i_digit;
        default: r_value[3:0]   <= i_digit;
      endcase
      // The first digit restarts the flag, so a new entry forgets an old error.
      r_bad <= (i_pos == 2'd0) ? w_digit_bad : (r_bad | w_digit_bad);
    end
  end

  assign o_value = r_value;
  assign o_bad   = r_bad;

endmodule

// File: rtl/id_checker.sv
// id_checker: collects a 4-digit BCD player ID and searches the ID ROM for it.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   b_id, idDigit       - digit button pulse and the BCD digit it carries
//   logoutIN            - logout pulse from the password stage
//   ROM_data, ROM_addr  - ID ROM read port (data valid 2 cycles after address)
//   matchedID, idFailed - one-cycle accept / reject pulses
//   internalPlayerIDOUT - matching ROM index or GUEST_SLOT, held until logout
//   isGuestOUT          - accepted ID was the guest ID, held until logout
//   awaitingID          - high while digits are being collected
module id_checker
  import id_checker_pkg::*;
#(
  parameter int unsigned NUM_IDS    = 7,
  parameter logic [15:0] GUEST_ID   = 16'h0000,
  parameter logic [2:0]  GUEST_SLOT = id_checker_pkg::GUEST_SLOT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        b_id,
  input  logic [3:0]  idDigit,
  input  logic        logoutIN,
  input  logic [15:0] ROM_data,
  output logic [4:0]  ROM_addr,
  output logic        matchedID,
  output logic        idFailed,
  output logic [2:0]  internalPlayerIDOUT,
  output logic        isGuestOUT,
  output logic        awaitingID
);

  state_t      r_state;
  logic [4:0]  r_idx;
  logic [15:0] r_romID;
  logic        r_eq;
  logic        w_capture;
  logic [1:0]  w_pos;
  logic [15:0] w_userID;
  logic        w_bad;

  always_comb begin
    w_capture = 1'b0;
    w_pos     = 2'd0;
    case (r_state)
      S_DIG1: begin w_capture = b_id; w_pos = 2'd0; end
      S_DIG2: begin w_capture = b_id; w_pos = 2'd1; end
      S_DIG3: begin w_capture = b_id; w_pos = 2'd2; end
      S_DIG4: begin w_capture = b_id; w_pos = 2'd3; end
      default: ;
    endcase
  end

  bcd_digit_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_capture),
    .i_pos     (w_pos),
    .i_digit   (idDigit),
    .o_value   (w_userID),
    .o_bad     (w_bad)
  );

  // Pulses and held outputs are written on the transition into MATCH/FAIL,
  // so they are visible during the MATCH/FAIL cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state             <= S_DIG1;
      r_idx               <= '0;
      r_romID             <= '0;
      r_eq                <= 1'b0;
      ROM_addr            <= '0;
      matchedID           <= 1'b0;
      idFailed            <= 1'b0;
      internalPlayerIDOUT <= '0;
      isGuestOUT          <= 1'b0;
      awaitingID          <= 1'b1;
    end else begin
      matchedID <= 1'b0;
      idFailed  <= 1'b0;
      case (r_state)
        S_DIG1: if (b_id) r_state <= S_DIG2;
        S_DIG2: if (b_id) r_state <= S_DIG3;
        S_DIG3: if (b_id) r_state <= S_DIG4;
        S_DIG4: if (b_id) begin
          r_state    <= S_CHECK;
          awaitingID <= 1'b0;
        end
        S_CHECK: begin
          if (w_bad) begin
            r_state  <= S_FAIL;
            idFailed <= 1'b1;
          end else if (w_userID == GUEST_ID) begin
            r_state             <= S_MATCH;
            matchedID           <= 1'b1;
            internalPlayerIDOUT <= GUEST_SLOT;
            isGuestOUT          <= 1'b1;
          end else begin
            ROM_addr <= r_idx;
            r_state  <= S_CYC1;
          end
        end
        S_CYC1:  r_state <= S_CYC2;
        S_CYC2:  r_state <= S_CATCH;
        S_CATCH: begin
          r_romID <= ROM_data;
          r_state <= S_EVAL;
        end
        // Equality is registered so the ROM data path and the 16-bit compare
        // sit in separate cycles; each entry costs five cycles in total.
        S_EVAL: begin
          r_eq    <= (r_romID == w_userID);
          r_state <= S_COMPARE;
        end
        S_COMPARE: begin
          if (r_eq) begin
            r_state             <= S_MATCH;
            matchedID           <= 1'b1;
            internalPlayerIDOUT <= r_idx[2:0];
            isGuestOUT          <= 1'b0;
          end else if (r_idx == 5'(NUM_IDS - 1)) begin
            r_state  <= S_FAIL;
            idFailed <= 1'b1;
          end else begin
            r_idx    <= r_idx + 5'd1;
            ROM_addr <= r_idx + 5'd1;
            r_state  <= S_CYC1;
          end
        end
        S_MATCH: r_state <= S_LOCKED;
        S_LOCKED: if (logoutIN) begin
          internalPlayerIDOUT <= '0;
          isGuestOUT          <= 1'b0;
          r_idx               <= '0;
          ROM_addr            <= '0;
          awaitingID          <= 1'b1;
          r_state             <= S_DIG1;
        end
        S_FAIL: begin
          r_idx      <= '0;
          ROM_addr   <= '0;
          awaitingID <= 1'b1;
          r_state    <= S_DIG1;
        end
        default: r_state <= S_DIG1;
      endcase
    end
  end

endmodule

// File: tb/tb_id_checker.sv
module tb_id_checker;

  localparam int NUM = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        b_id = 1'b0;
  logic [3:0]  idDigit = '0;
  logic        logoutIN = 1'b0;
  logic [15:0] ROM_data;
  logic [4:0]  ROM_addr;
  logic        matchedID, idFailed, isGuestOUT, awaitingID;
  logic [2:0]  internalPlayerIDOUT;

  logic [15:0] rom [0:31];
  logic [15:0] rom_p1;

  int checks = 0;
  int failures = 0;

  id_checker #(.NUM_IDS(NUM), .GUEST_ID(16'h0000), .GUEST_SLOT(3'd7)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .b_id                (b_id),
    .idDigit             (idDigit),
    .logoutIN            (logoutIN),
    .ROM_data            (ROM_data),
    .ROM_addr            (ROM_addr),
    .matchedID           (matchedID),
    .idFailed            (idFailed),
    .internalPlayerIDOUT (internalPlayerIDOUT),
    .isGuestOUT          (isGuestOUT),
    .awaitingID          (awaitingID)
  );

  always #5 clk = ~clk;

  // ROM with two cycles of read latency
  always @(posedge clk) begin
    rom_p1   <= rom[ROM_addr];
    ROM_data <= rom_p1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d, input bit gaps);
    b_id = 1'b1;
    idDigit = d;
    tick();
    b_id = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
  endtask

  // Reference: outcome and latency (cycles after the 4th press) from the rules
  task automatic model(input logic [15:0] uid, output bit is_match, output int lat,
                       output int id, output bit guest);
    bit bad;
    bad = 0;
    for (int i = 0; i < 4; i++) if (((uid >> (4 * i)) & 16'hF) > 9) bad = 1;
    is_match = 0; lat = 2; id = 0; guest = 0;
    if (bad) return;
    if (uid == 16'h0000) begin
      is_match = 1; id = 7; guest = 1;
      return;
    end
    for (int k = 0; k < NUM; k++) begin
      if (rom[k] == uid) begin
        is_match = 1; lat = 7 + 5 * k; id = k;
        return;
      end
    end
    lat = 2 + 5 * NUM;
  endtask

  // Enter an ID, stir b_id during the search, check outcome and timing.
  task automatic run_entry(input string tg, input logic [15:0] uid, input bit noise,
                           output bit got_match);
    bit em, eg, found;
    int el, eid, n;
    model(uid, em, el, eid, eg);
    for (int i = 3; i >= 0; i--) press(4'((uid >> (4 * i)) & 16'hF), i != 0);
    found = 0;
    n = 1;
    while (!found && n <= 80) begin
      if (n == 1) chk({tg, ".await_drop"}, awaitingID, 0);
      if (matchedID || idFailed) begin
        found = 1;
      end else begin
        if (em && !eg && n == 2 + 5 * eid) chk({tg, ".rom_addr"}, ROM_addr, eid);
        if (noise) begin
          b_id = 1'($urandom_range(0, 1));
          idDigit = 4'($urandom);
        end
        tick();
        b_id = 1'b0;
        n++;
      end
    end
    chk({tg, ".latency"}, found ? n : 0, el);
    chk({tg, ".matched"}, matchedID, em);
    chk({tg, ".failed"}, idFailed, !em);
    got_match = matchedID;
    if (em) begin
      chk({tg, ".id"}, internalPlayerIDOUT, eid);
      chk({tg, ".guest"}, isGuestOUT, eg);
      if (eg) chk({tg, ".guest_addr"}, ROM_addr, 0);
      // logout during the MATCH cycle must be ignored
      logoutIN = 1'($urandom_range(0, 1));
      tick();
      logoutIN = 1'b0;
      chk({tg, ".pulse_end"}, matchedID, 0);
      chk({tg, ".id_held"}, internalPlayerIDOUT, eid);
    end else begin
      tick();
      chk({tg, ".await_back"}, awaitingID, 1);
      chk({tg, ".fail_end"}, idFailed, 0);
    end
  endtask

  task automatic logout(input string tg);
    logoutIN = 1'b1;
    tick();
    logoutIN = 1'b0;
    chk({tg, ".lo_id"}, internalPlayerIDOUT, 0);
    chk({tg, ".lo_guest"}, isGuestOUT, 0);
    chk({tg, ".lo_await"}, awaitingID, 1);
  endtask

  initial begin
    bit m;
    logic [15:0] uid;
    for (int i = 0; i < 32; i++) rom[i] = 16'hFFFF;
    rom[0] = 16'h1234; rom[3] = 16'h5678; rom[6] = 16'h9021; rom[7] = 16'h4321;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst.addr", ROM_addr, 0);
    chk("rst.matched", matchedID, 0);
    chk("rst.failed", idFailed, 0);
    chk("rst.id", internalPlayerIDOUT, 0);
    chk("rst.guest", isGuestOUT, 0);
    chk("rst.await", awaitingID, 1);

    run_entry("hit3", 16'h5678, 0, m);
    if (m) logout("hit3");
    run_entry("guest", 16'h0000, 0, m);
    if (m) logout("guest");
    run_entry("miss", 16'h4444, 0, m);
    run_entry("bad", 16'h1A34, 0, m);
    chk("bad.addr", ROM_addr, 0);
    run_entry("beyond", 16'h4321, 1, m);

    run_entry("hit0", 16'h1234, 0, m);
    for (int i = 0; i < 5; i++) press(4'($urandom), 0);
    chk("locked.id", internalPlayerIDOUT, 0);
    chk("locked.await", awaitingID, 0);
    chk("locked.matched", matchedID, 0);
    logout("hit0");
    run_entry("hit6", 16'h9021, 0, m);
    if (m) logout("hit6");

    // reset during CYC2 of index 2
    for (int i = 0; i < 4; i++) press(4'd4, 0);
    repeat (12) tick();
    chk("rstmid.addr2", ROM_addr, 2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid.addr", ROM_addr, 0);
    chk("rstmid.matched", matchedID, 0);
    chk("rstmid.failed", idFailed, 0);
    chk("rstmid.id", internalPlayerIDOUT, 0);
    chk("rstmid.guest", isGuestOUT, 0);
    chk("rstmid.await", awaitingID, 1);
    run_entry("after_rst", 16'h0000, 0, m);
    if (m) logout("after_rst");

    // randomized sessions, ROM contents (with duplicates) reshuffled each time
    for (int t = 0; t < 25; t++) begin
      for (int k = 0; k < 8; k++) begin
        rom[k] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end
      if ($urandom_range(0, 1)) rom[$urandom_range(1, 6)] = rom[$urandom_range(0, 6)];
      case ($urandom_range(0, 4))
        0: uid = 16'h0000;
        1: uid = {4'($urandom), 12'h123};
        2, 3: uid = rom[$urandom_range(0, 7)];
        default: uid = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                        4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      endcase
      run_entry($sformatf("rnd%0d", t), uid, 1, m);
      if (m) logout($sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_checker.md
# id_checker

Front-end login stage that collects a 4-digit BCD player ID one digit per `b_id` press and searches the ID ROM for it. It feeds the password-checking stage: on a hit (or on the guest ID) it pulses `matchedID` and holds the internal player ID and guest flag. It then stays locked until the password stage returns a logout pulse.

## Interface

Parameters:
- `NUM_IDS`, 7: registered ID entries in ROM, addresses 0..NUM_IDS-1 (1..31).
- `GUEST_ID`, 16'h0000: ID accepted without ROM search.
- `GUEST_SLOT`, 3'd7: internal player ID reported for a guest.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `b_id` in 1: one-cycle pulse from the debounced ID button.
- `idDigit` in 4: BCD digit sampled with `b_id`.
- `logoutIN` in 1: one-cycle logout pulse from the password stage.
- `ROM_data` in 16: ID ROM read data, valid 2 cycles after `ROM_addr` changes.
- `ROM_addr` out 5: ID ROM address.
- `matchedID` out 1: one-cycle pulse on an accepted ID.
- `idFailed` out 1: one-cycle pulse on a rejected ID.
- `internalPlayerIDOUT` out 3: matching ROM index, or `GUEST_SLOT`.
- `isGuestOUT` out 1: accepted ID was `GUEST_ID`.
- `awaitingID` out 1: high while in DIG1..DIG4.

## Operation

Reset values: `ROM_addr`=0, `matchedID`=0, `idFailed`=0, `internalPlayerIDOUT`=0, `isGuestOUT`=0, `awaitingID`=1. Internal state: `userID`=0, `idx`=0, `bad`=0, state=DIG1.

States and transitions:
- **DIG1..DIG4**: capture a digit on `b_id` and advance.
  - Digits fill `userID[15:12]`, `[11:8]`, `[7:4]`, `[3:0]` in that order.
  - A digit greater than 9 sets sticky flag `bad`.
  - DIG1 clears `bad` and `idx` on entry.
- **CHECK** (after DIG4):
  - If `bad`: go to FAIL.
  - Else if `userID`==`GUEST_ID`: go to MATCH with guest=1.
  - Else: `ROM_addr`<=`idx`, go to CYC1.
- **CYC1 → CYC2 → CATCH**: CATCH registers `ROM_data` into `romID`.
- **COMPARE**:
  - Equal: go to MATCH with ID=`idx`.
  - Else if `idx`==NUM_IDS-1: go to FAIL.
  - Else: `idx`++, `ROM_addr`<=`idx`+1, go to CYC1.
- **MATCH**:
  - Pulse `matchedID` one cycle.
  - Load `internalPlayerIDOUT` and `isGuestOUT`; hold both stable.
  - Go to LOCKED.
- **LOCKED**: on `logoutIN`, clear `internalPlayerIDOUT`/`isGuestOUT` to 0 and go to DIG1.
- **FAIL**: pulse `idFailed` one cycle, go to DIG1.

Boundary rules:
- `b_id` outside DIG states is ignored; no queuing.
- `logoutIN` outside LOCKED is ignored.
- `logoutIN` is accepted even on the same cycle MATCH→LOCKED completes, only if it arrives in LOCKED.
- If ROM holds duplicate IDs, the first (lowest) index wins.
- `rst` mid-search or in LOCKED returns every output to its reset value the next cycle.
- `idx` is 5 bits; `ROM_addr` never exceeds NUM_IDS-1.

## Timing

Let T be the cycle in which the 4th `b_id` is sampled.
- **Guest ID**: `matchedID` high at T+2.
- **ROM hit at index k**: `ROM_addr`=k from T+2+5k. `matchedID` is high at T+7+5k, with `internalPlayerIDOUT` valid in the same cycle and held.
- **Miss**: `idFailed` high at T+2+5·NUM_IDS (T+37 for default).
- **Invalid digit**: `idFailed` high at T+2.
- `awaitingID` drops at T+1 and rises in the first DIG1 cycle.
- All outputs are registered.

## Structure

- Shared login package holds:
  - state encoding (DIG1..FAIL);
  - `ID_DIGITS`=4;
  - ROM latency constant `ROM_WAIT`=2, shared with the password stage;
  - `GUEST_SLOT`.
- Natural sub-module: `bcd_digit_shifter`, which captures 4 digits and flags `bad`.
- Search FSM stays in `id_checker`.

## Test plan

- ROM {0:1234, 3:5678, 6:9021}; enter 5,6,7,8 → `matchedID` at T+22, `internalPlayerIDOUT`=3, `isGuestOUT`=0.
- Enter 0,0,0,0 → `matchedID` at T+2, ID=7, `isGuestOUT`=1; no ROM walk (`ROM_addr` stays 0).
- Enter 4,4,4,4 → `idFailed` at T+37, `awaitingID`=1 next cycle, no `matchedID`.
- Enter 1,A,3,4 → `idFailed` at T+2, ROM never addressed.
- Match 1,2,3,4; press `b_id` 5 times → outputs unchanged. Then pulse `logoutIN` → ID/guest cleared, new entry 9,0,2,1 gives ID=6 at T+37.
- Assert `rst` during CYC2 of index 2 → next cycle all outputs at reset values, state DIG1.
